// File: rtl/maze_game.sv
// Grid maze game: one-step moves on a COLS x ROWS board with traps, a goal,
// a life counter and an optional move limit. All outputs come straight from registers.
module maze_game #(
  parameter int                     COLS      = 4,
  parameter int                     ROWS      = 4,
  parameter int                     START_X   = 0,
  parameter int                     START_Y   = 0,
  parameter int                     GOAL_X    = 3,
  parameter int                     GOAL_Y    = 3,
  parameter logic [ROWS*COLS-1:0]   TRAP_MAP  = 16'h0420,
  parameter int                     LIVES     = 3,
  parameter int                     MAX_MOVES = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  N,
  input  logic                                  S,
  input  logic                                  E,
  input  logic                                  W,
  output logic                                  WIN,
  output logic                                  DIE,
  output logic                                  hit,
  output logic                                  bad_move,
  output logic [$clog2(COLS)-1:0]               pos_x,
  output logic [$clog2(ROWS)-1:0]               pos_y,
  output logic [$clog2(LIVES+1)-1:0]            lives,
  output logic [(($clog2(MAX_MOVES+1) < 6) ? 6 : $clog2(MAX_MOVES+1))-1:0] moves,
  output logic [1:0]                            dbg_state_o
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(LIVES+1);
  localparam int MW = ($clog2(MAX_MOVES+1) < 6) ? 6 : $clog2(MAX_MOVES+1);

  // dbg_state_o encoding: 0=PLAY, 1=HIT, 2=WON, 3=DEAD
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    WON  = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, tx;
  logic [YW-1:0] y_q, y_d, ty;
  logic [LW-1:0] lives_q, lives_d, lives_dec;
  logic [MW-1:0] moves_q, moves_d, moves_inc;
  logic          bad_q, bad_d;
  logic [2:0]    dir_cnt;
  logic          off_grid, is_goal, is_trap, at_limit;

  // Candidate target for a single-direction request; edges are caught
  // before any arithmetic so coordinates never wrap.
  always_comb begin
    dir_cnt  = {2'b00, N} + {2'b00, S} + {2'b00, E} + {2'b00, W};
    tx       = x_q;
    ty       = y_q;
    off_grid = 1'b0;
    if (E) begin
      if (x_q == XW'(COLS-1)) off_grid = 1'b1;
      else                    tx = x_q + XW'(1);
    end else if (W) begin
      if (x_q == '0) off_grid = 1'b1;
      else           tx = x_q - XW'(1);
    end else if (S) begin
      if (y_q == YW'(ROWS-1)) off_grid = 1'b1;
      else                    ty = y_q + YW'(1);
    end else if (N) begin
      if (y_q == '0) off_grid = 1'b1;
      else           ty = y_q - YW'(1);
    end

    is_trap = 1'b0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (i == (int'(ty) * COLS + int'(tx))) is_trap = TRAP_MAP[i];
    end
    is_goal = (int'(tx) == GOAL_X) && (int'(ty) == GOAL_Y);

    // Saturating count only matters with an unlimited budget.
    moves_inc = (moves_q == '1) ? moves_q : moves_q + MW'(1);
    at_limit  = (MAX_MOVES != 0) && (int'(moves_inc) == MAX_MOVES);
    lives_dec = (lives_q != '0) ? lives_q - LW'(1) : '0;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    moves_d = moves_q;
    bad_d   = 1'b0;
    case (state_q)
      PLAY: begin
        if (dir_cnt > 3'd1) begin
          bad_d = 1'b1;
        end else if (dir_cnt == 3'd1) begin
          if (off_grid) begin
            bad_d = 1'b1;
          end else begin
            x_d     = tx;
            y_d     = ty;
            moves_d = moves_inc;
            if (is_goal) begin
              state_d = WON;
            end else if (is_trap) begin
              lives_d = lives_dec;
              // A trap on the last allowed move still ends the game.
              if (lives_dec == '0 || at_limit) state_d = DEAD;
              else                             state_d = HIT;
            end else if (at_limit) begin
              state_d = DEAD;
            end
          end
        end
      end
      HIT: begin
        x_d     = XW'(START_X);
        y_d     = YW'(START_Y);
        state_d = PLAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= PLAY;
      x_q     <= XW'(START_X);
      y_q     <= YW'(START_Y);
      lives_q <= LW'(LIVES);
      moves_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      moves_q <= moves_d;
      bad_q   <= bad_d;
    end
  end

  assign WIN         = (state_q == WON);
  assign DIE         = (state_q == DEAD);
  assign hit         = (state_q == HIT);
  assign bad_move    = bad_q;
  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign lives       = lives_q;
  assign moves       = moves_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_maze_game.sv
// Bench for maze_game: three configurations driven by the same inputs, each
// tracked by a coordinate-level model of the game rules, plus directed scenarios.
module tb_maze_game;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;

  // dut0: defaults; dut1: MAX_MOVES=6; dut2: 8x2, goal (7,1), no traps, 1 life, unlimited
  logic       win0, die0, hit0, bad0; logic [1:0] x0, y0, l0; logic [5:0] m0; logic [1:0] st0;
  logic       win1, die1, hit1, bad1; logic [1:0] x1, y1, l1; logic [5:0] m1; logic [1:0] st1;
  logic       win2, die2, hit2, bad2; logic [2:0] x2; logic y2, l2; logic [5:0] m2; logic [1:0] st2;

  maze_game dut0 (
    .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
    .WIN(win0), .DIE(die0), .hit(hit0), .bad_move(bad0),
    .pos_x(x0), .pos_y(y0), .lives(l0), .moves(m0), .dbg_state_o(st0)
  );

  maze_game #(.MAX_MOVES(6)) dut1 (
    .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
    .WIN(win1), .DIE(die1), .hit(hit1), .bad_move(bad1),
    .pos_x(x1), .pos_y(y1), .lives(l1), .moves(m1), .dbg_state_o(st1)
  );

  maze_game #(.COLS(8), .ROWS(2), .GOAL_X(7), .GOAL_Y(1), .TRAP_MAP(16'h0000),
              .LIVES(1), .MAX_MOVES(0)) dut2 (
    .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
    .WIN(win2), .DIE(die2), .hit(hit2), .bad_move(bad2),
    .pos_x(x2), .pos_y(y2), .lives(l2), .moves(m2), .dbg_state_o(st2)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model: status 0=playing 1=hit 2=won 3=dead
  int cfg_cols[3]  = '{4, 4, 8};
  int cfg_rows[3]  = '{4, 4, 2};
  int cfg_gx[3]    = '{3, 3, 7};
  int cfg_gy[3]    = '{3, 3, 1};
  int cfg_lives[3] = '{3, 3, 1};
  int cfg_maxm[3]  = '{32, 6, 0};
  logic [15:0] cfg_trap[3] = '{16'h0420, 16'h0420, 16'h0000};

  int m_x[3], m_y[3], m_lv[3], m_mv[3], m_st[3], m_bad[3];

  task automatic model_step(input int k, input bit rst, input bit dn, input bit ds,
                            input bit de, input bit dw);
    int cnt, nx, ny;
    m_bad[k] = 0;
    if (rst) begin
      m_x[k] = 0; m_y[k] = 0; m_lv[k] = cfg_lives[k]; m_mv[k] = 0; m_st[k] = 0;
    end else if (m_st[k] == 1) begin
      m_x[k] = 0; m_y[k] = 0; m_st[k] = 0;
    end else if (m_st[k] == 0) begin
      cnt = int'(dn) + int'(ds) + int'(de) + int'(dw);
      nx  = m_x[k] + int'(de) - int'(dw);
      ny  = m_y[k] + int'(ds) - int'(dn);
      if (cnt > 1) begin
        m_bad[k] = 1;
      end else if (cnt == 1) begin
        if (nx < 0 || ny < 0 || nx >= cfg_cols[k] || ny >= cfg_rows[k]) begin
          m_bad[k] = 1;
        end else begin
          m_x[k] = nx; m_y[k] = ny;
          if (!(cfg_maxm[k] == 0 && m_mv[k] == 63)) m_mv[k]++;
          if (nx == cfg_gx[k] && ny == cfg_gy[k]) m_st[k] = 2;
          else begin
            if (cfg_trap[k][ny*cfg_cols[k] + nx]) begin
              m_lv[k]--;
              m_st[k] = (m_lv[k] == 0) ? 3 : 1;
            end
            if (m_st[k] != 3 && cfg_maxm[k] != 0 && m_mv[k] == cfg_maxm[k]) m_st[k] = 3;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int ox, oy, ol, om, ow, od, oh, ob, os;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin ox = x0; oy = y0; ol = l0; om = m0; ow = win0; od = die0; oh = hit0; ob = bad0; os = st0; end
        1: begin ox = x1; oy = y1; ol = l1; om = m1; ow = win1; od = die1; oh = hit1; ob = bad1; os = st1; end
        default: begin ox = x2; oy = y2; ol = l2; om = m2; ow = win2; od = die2; oh = hit2; ob = bad2; os = st2; end
      endcase
      check_eq($sformatf("d%0d.pos_x", k), ox, m_x[k]);
      check_eq($sformatf("d%0d.pos_y", k), oy, m_y[k]);
      check_eq($sformatf("d%0d.lives", k), ol, m_lv[k]);
      check_eq($sformatf("d%0d.moves", k), om, m_mv[k]);
      check_eq($sformatf("d%0d.WIN", k), ow, int'(m_st[k] == 2));
      check_eq($sformatf("d%0d.DIE", k), od, int'(m_st[k] == 3));
      check_eq($sformatf("d%0d.hit", k), oh, int'(m_st[k] == 1));
      check_eq($sformatf("d%0d.bad_move", k), ob, m_bad[k]);
      check_eq($sformatf("d%0d.state", k), os, m_st[k]);
    end
  endtask

  // driver: apply one vector, update model at the edge, compare on the falling edge
  task automatic step(input bit rst, input bit dn, input bit ds, input bit de, input bit dw);
    reset = !rst; n = dn; s = ds; e = de; w = dw;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, rst, dn, ds, de, dw);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();   step(1, 0, 0, 0, 0); endtask
  task automatic idle();       step(0, 0, 0, 0, 0); endtask
  task automatic go_n();       step(0, 1, 0, 0, 0); endtask
  task automatic go_s();       step(0, 0, 1, 0, 0); endtask
  task automatic go_e();       step(0, 0, 0, 1, 0); endtask
  task automatic go_w();       step(0, 0, 0, 0, 1); endtask

  initial begin
    int r, sel, bits;

    // defaults: walk to the goal
    do_reset(); do_reset();
    check_eq("rst.pos_x", x0, 0);   check_eq("rst.pos_y", y0, 0);
    check_eq("rst.lives", l0, 3);   check_eq("rst.moves", m0, 0);
    check_eq("rst.WIN", win0, 0);   check_eq("rst.DIE", die0, 0);
    check_eq("rst.hit", hit0, 0);   check_eq("rst.bad", bad0, 0);
    go_e(); go_e(); go_e(); go_s(); go_s(); go_s();
    check_eq("goal.WIN", win0, 1);  check_eq("goal.DIE", die0, 0);
    check_eq("goal.moves", m0, 6);  check_eq("goal.lives", l0, 3);
    check_eq("goal.pos_x", x0, 3);  check_eq("goal.pos_y", y0, 3);
    check_eq("goal_vs_limit.WIN", win1, 1); check_eq("goal_vs_limit.DIE", die1, 0);
    go_n(); go_w(); step(0, 1, 1, 1, 1);
    check_eq("won_frozen.pos_x", x0, 3); check_eq("won_frozen.moves", m0, 6);
    check_eq("won_frozen.bad", bad0, 0); check_eq("won_frozen.WIN", win0, 1);

    // traps
    do_reset(); go_s(); go_e();
    check_eq("trap1.lives", l0, 2); check_eq("trap1.hit", hit0, 1);
    check_eq("trap1.moves", m0, 2); check_eq("trap1.pos_x", x0, 1);
    step(0, 1, 0, 0, 1);
    check_eq("respawn.pos_x", x0, 0); check_eq("respawn.pos_y", y0, 0);
    check_eq("respawn.hit", hit0, 0); check_eq("respawn.bad", bad0, 0);
    go_s(); go_e(); idle(); go_s(); go_e();
    check_eq("trap3.lives", l0, 0); check_eq("trap3.DIE", die0, 1);
    check_eq("trap3.hit", hit0, 0); check_eq("trap3.WIN", win0, 0);

    // rejected inputs
    do_reset(); go_n();
    check_eq("rej_n.bad", bad0, 1); check_eq("rej_n.pos_y", y0, 0); check_eq("rej_n.moves", m0, 0);
    idle();
    check_eq("rej_pulse.bad", bad0, 0);
    step(0, 1, 0, 1, 0);
    check_eq("rej_ne.bad", bad0, 1); check_eq("rej_ne.pos_x", x0, 0);
    go_w();
    check_eq("rej_w.bad", bad0, 1);

    // move limit
    do_reset();
    for (int i = 0; i < 16; i++) begin go_e(); go_w(); end
    check_eq("limit.DIE", die0, 1);   check_eq("limit.moves", m0, 32);
    check_eq("limit6.DIE", die1, 1);  check_eq("limit6.moves", m1, 6);
    check_eq("unlim.DIE", die2, 0);   check_eq("unlim.moves", m2, 32);

    // reset mid-game
    do_reset(); go_s(); go_e(); do_reset();
    check_eq("rst_hit.pos_x", x0, 0); check_eq("rst_hit.lives", l0, 3);
    check_eq("rst_hit.moves", m0, 0); check_eq("rst_hit.hit", hit0, 0);
    go_s(); go_e(); idle(); go_s(); go_e(); idle(); go_s(); go_e();
    check_eq("dead.DIE", die0, 1);
    do_reset();
    check_eq("rst_dead.DIE", die0, 0); check_eq("rst_dead.state", st0, 0);

    // non-default grid
    do_reset();
    for (int i = 0; i < 7; i++) go_e();
    go_s();
    check_eq("wide.WIN", win2, 1); check_eq("wide.moves", m2, 8);
    do_reset(); go_s(); go_s();
    check_eq("wide_rej.bad", bad2, 1); check_eq("wide_rej.pos_y", y2, 1);

    // randomized play
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 24);
      if (r == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        if (sel < 2)      bits = 0;
        else if (sel < 8) bits = 1 << $urandom_range(0, 3);
        else              bits = $urandom_range(0, 15);
        step(0, bits[3], bits[2], bits[1], bits[0]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/maze_game.md
Name: maze_game

Overview:
Parametrised successor to the four-direction adventure FSM. The player moves on a COLS x ROWS grid using the N/S/E/W inputs. Trap cells cost a life, the goal cell wins, and the game also ends on running out of lives or moves. WIN and DIE keep their existing meaning and sticky behaviour, so the existing bench style (vectors applied, outputs sampled after posedge) carries over unchanged.

Parameters:
COLS, 4, grid width (2..16)
ROWS, 4, grid height (2..16)
START_X, 0, respawn/reset column
START_Y, 0, respawn/reset row
GOAL_X, 3, goal column
GOAL_Y, 3, goal row
TRAP_MAP, 16'h0420, ROWS*COLS bits; bit (y*COLS+x)=1 marks a trap (default: cells (1,1),(2,2)); goal and start cells must be 0
LIVES, 3, lives at reset (1..15)
MAX_MOVES, 32, legal-move limit; 0 = unlimited

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
N  in  1  move north (y-1)
S  in  1  move south (y+1)
E  in  1  move east (x+1)
W  in  1  move west (x-1)
WIN  out  1  sticky, goal reached
DIE  out  1  sticky, lives or moves exhausted
hit  out  1  high for exactly the one HIT cycle after a trap entry
bad_move  out  1  one-cycle pulse, rejected input
pos_x  out  $clog2(COLS)  current column
pos_y  out  $clog2(ROWS)  current row
lives  out  $clog2(LIVES+1)  remaining lives
moves  out  $clog2(MAX_MOVES+1) (min 6)  legal moves taken

Behaviour:
- Reset (reset==0 at posedge): state=PLAY, pos=(START_X,START_Y), lives=LIVES, moves=0, WIN=DIE=hit=bad_move=0. Reset overrides everything, including mid-HIT, WIN and DIE.
- All outputs are registered. Any effect of inputs sampled at edge k is visible after edge k (latency 1 edge).
- States: PLAY, HIT, WON, DEAD.
- PLAY, all inputs 0: no change.
- PLAY, more than one direction asserted: no move, bad_move=1 for one cycle, moves unchanged.
- PLAY, exactly one direction, target off-grid (N at y=0, S at y=ROWS-1, W at x=0, E at x=COLS-1): no move, bad_move=1, moves unchanged.
- PLAY, exactly one direction, legal target: pos=target and moves+1, saturating at all-ones when MAX_MOVES=0. Then evaluate in priority order:
  1) Target is goal: go to WON, WIN=1.
  2) Target is trap: lives-1. If the new lives==0, go to DEAD, DIE=1 (no HIT cycle). Otherwise go to HIT, hit=1.
  3) MAX_MOVES!=0 and new moves==MAX_MOVES: go to DEAD, DIE=1.
  4) Otherwise stay in PLAY.
- Goal beats the move limit on the same move. A trap on the final allowed move costs a life and then DIE via rule 3.
- HIT (exactly one cycle): inputs ignored (no bad_move), hit=1, pos shown is the trap cell. At the next edge: pos=(START_X,START_Y), hit=0, back to PLAY. moves is not cleared.
- WON/DEAD: terminal until reset. All inputs ignored, bad_move=0, pos/lives/moves frozen.
- WIN and DIE are never both 1.
- Widths: pos_x/pos_y compare against COLS-1/ROWS-1 without wrap-around; no arithmetic may underflow.

Test Plan:
1. Defaults: reset low for 2 cycles, then E,E,E,S,S,S, one per cycle -> after the 6th edge pos=(3,3), WIN=1, DIE=0, moves=6, lives=3. Further inputs leave all outputs unchanged.
2. Trap:
   - S then E (enters (1,1)) -> lives=2, hit=1 for one cycle, moves=2.
   - Next edge: pos=(0,0), hit=0.
   - Repeat twice more -> third entry gives lives=0, DIE=1, no hit pulse.
3. Rejected input:
   - N at (0,0) -> bad_move=1 one cycle, pos=(0,0), moves=0.
   - N+E together -> bad_move=1, no move.
   - W at (0,0) -> bad_move=1.
4. Move limit: alternate E,W 16 times (32 legal moves, no traps) -> after the 32nd edge DIE=1, moves=32. Rerun with MAX_MOVES=6 on the scenario-1 path -> WIN=1 (goal beats limit).
5. Reset mid-operation:
   - reset low during HIT -> next edge pos=(0,0), lives=3, moves=0, hit=0.
   - reset low in DEAD -> DIE=0, state PLAY.
6. Non-default params COLS=8, ROWS=2, GOAL=(7,1), TRAP_MAP=0, LIVES=1: E x7, S -> WIN=1, moves=8. S at y=1 is rejected with bad_move=1.
